// File: rtl/dose_scheduler_if.sv
// Servo-driver / speaker / keypad handshake bundle of the dose scheduler.
// master = scheduler side, slave = servo driver + keypad + speaker side.
interface dose_scheduler_if;
  logic       disp_req;
  logic [1:0] disp_user;
  logic       disp_ack;
  logic       alarm;
  logic       ack;
  logic       missed;

  modport master (
    output disp_req, disp_user, alarm, missed,
    input  disp_ack, ack
  );
  modport slave (
    input  disp_req, disp_user, alarm, missed,
    output disp_ack, ack
  );
endinterface

// File: rtl/dose_scheduler.sv
// Dose scheduler: scans per-user BCD dose slots on each new minute, then serves
// pending users round-robin (dispense handshake, then alarm until ack or timeout).
// Optional per-user missed-dose counters are enabled with DOSE_MISSED_CNT_EN.
module dose_scheduler #(
  parameter int NUSR     = 4,
  parameter int SLOTS    = 2,
  parameter int ALARM_TO = 600000
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic [15:0]                tiempo,
  input  logic [NUSR*SLOTS*16-1:0]   sched,
  input  logic [NUSR-1:0]            user_en,
  dose_scheduler_if.master           bus,
`ifdef DOSE_MISSED_CNT_EN
  output logic [8*NUSR-1:0]          missed_cnt,
`endif
  output logic [NUSR-1:0]            pending
);

  localparam int NENT = NUSR * SLOTS;
  localparam int IW   = (NENT > 1) ? $clog2(NENT) : 1;
  localparam int UW   = (NUSR > 1) ? $clog2(NUSR) : 1;
  localparam int CW   = $clog2(ALARM_TO + 1);

  typedef enum logic [2:0] {IDLE, SCAN, GRANT, DISPENSE, ALERT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [UW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [UW-1:0]   disp_user_q, disp_user_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     last_min_q, last_min_d;
  logic            min_flag_q, min_flag_d;
  logic [NUSR-1:0] pending_q, pending_d;
  logic            missed_q, missed_d;

  logic [NENT-1:0] ent_hit;
  logic [UW-1:0]   pick;

  function automatic logic bcd_ok(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
           (v[7:4]   <= 4'd9) && (v[3:0]  <= 4'd9);
  endfunction

  // Per-entry match against the latched minute; non-BCD entries are unused slots.
  for (genvar k = 0; k < NENT; k++) begin : g_ent
    assign ent_hit[k] = user_en[k / SLOTS] && bcd_ok(sched[16*k +: 16]) &&
                        (sched[16*k +: 16] == last_min_q);
  end

  // Round-robin pick: first pending user after rr_ptr, wrapping.
  always_comb begin
    logic found;
    int   cand;
    pick  = rr_ptr_q;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= NUSR; i++) begin
      cand = (int'(rr_ptr_q) + i) % NUSR;
      if (!found && pending_q[cand]) begin
        found = 1'b1;
        pick  = UW'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    disp_user_d = disp_user_q;
    cnt_d       = cnt_q;
    last_min_d  = last_min_q;
    min_flag_d  = min_flag_q;
    pending_d   = pending_q;
    missed_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (min_flag_q) begin
          min_flag_d = 1'b0;
          idx_d      = '0;
          state_d    = SCAN;
        end else if (|pending_q) begin
          state_d = GRANT;
        end
      end
      SCAN: begin
        for (int k = 0; k < NENT; k++)
          if (idx_q == IW'(k) && ent_hit[k]) pending_d[k / SLOTS] = 1'b1;
        if (idx_q == IW'(NENT - 1)) state_d = IDLE;
        else                        idx_d   = idx_q + 1'b1;
      end
      GRANT: begin
        disp_user_d = pick;
        rr_ptr_d    = pick;
        state_d     = DISPENSE;
      end
      DISPENSE: begin
        if (bus.disp_ack) begin
          cnt_d   = '0;
          state_d = ALERT;
        end
      end
      ALERT: begin
        // ack is checked first so it wins over a same-cycle timeout
        if (bus.ack) begin
          pending_d[disp_user_q] = 1'b0;
          state_d                = IDLE;
        end else if (cnt_q == CW'(ALARM_TO - 1)) begin
          pending_d[disp_user_q] = 1'b0;
          missed_d               = 1'b1;
          state_d                = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new minute seen this cycle outranks IDLE consuming the old flag.
    if (tiempo != last_min_q) begin
      last_min_d = tiempo;
      min_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rr_ptr_q    <= UW'(NUSR - 1);
      disp_user_q <= '0;
      cnt_q       <= '0;
      last_min_q  <= 16'hFFFF;
      min_flag_q  <= 1'b0;
      pending_q   <= '0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      disp_user_q <= disp_user_d;
      cnt_q       <= cnt_d;
      last_min_q  <= last_min_d;
      min_flag_q  <= min_flag_d;
      pending_q   <= pending_d;
      missed_q    <= missed_d;
    end
  end

`ifdef DOSE_MISSED_CNT_EN
  logic [NUSR-1:0][7:0] mcnt_q, mcnt_d;

  always_comb begin
    mcnt_d = mcnt_q;
    if (missed_d && mcnt_q[disp_user_q] != 8'hFF)
      mcnt_d[disp_user_q] = mcnt_q[disp_user_q] + 8'd1;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) mcnt_q <= '0;
    else      mcnt_q <= mcnt_d;
  end

  assign missed_cnt = mcnt_q;
`endif

  assign bus.disp_req  = (state_q == DISPENSE);
  assign bus.alarm     = (state_q == ALERT);
  assign bus.disp_user = 2'(disp_user_q);
  assign bus.missed    = missed_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_dose_scheduler.sv
// Self-checking bench for dose_scheduler: scan vector table plus hand-written
// sequences; served-user order is checked through an expected-user queue.
module tb_dose_scheduler;
  localparam int NUSR = 4;
  localparam int SLOTS = 2;
  localparam int ATO = 20;

  logic          clk;
  logic          RST;
  logic [15:0]   tiempo;
  logic [127:0]  sched;
  logic [3:0]    user_en;
  logic [3:0]    pending;
`ifdef DOSE_MISSED_CNT_EN
  logic [31:0]   missed_cnt;
`endif

  dose_scheduler_if bus();

  dose_scheduler #(.NUSR(NUSR), .SLOTS(SLOTS), .ALARM_TO(ATO)) dut (
    .clk(clk), .RST(RST), .tiempo(tiempo), .sched(sched), .user_en(user_en),
    .bus(bus),
`ifdef DOSE_MISSED_CNT_EN
    .missed_cnt(missed_cnt),
`endif
    .pending(pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int exp_q[$];
  int srv_lat = 1;
  int ack_lat = 1;
  bit ack_on = 1'b1;
  int miss_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input logic [3:0] en, input logic [127:0] s, input logic [15:0] t);
    RST = 1'b0; user_en = en; sched = s; tiempo = t;
    @(posedge clk); #1;
    RST = 1'b1;
  endtask

  function automatic logic [127:0] ent(input int k, input logic [15:0] v);
    logic [127:0] r;
    r = '1;
    r[16*k +: 16] = v;
    return r;
  endfunction

  // Servo driver / keypad model and served-order scoreboard.
  initial begin
    int   dcnt;
    int   acnt;
    logic req_d;
    dcnt = 0; acnt = 0; req_d = 1'b0;
    bus.disp_ack = 1'b0; bus.ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.disp_ack = 1'b0;
      bus.ack      = 1'b0;
      if (bus.missed === 1'b1) miss_seen++;
      if (bus.disp_req === 1'b1) begin
        if (!req_d) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL sb_extra: served user %0d, none expected", bus.disp_user);
          end else begin
            chk("sb_user", 32'(bus.disp_user), 32'(exp_q.pop_front()));
          end
        end
        dcnt++;
        if (dcnt == srv_lat) bus.disp_ack = 1'b1;
      end else dcnt = 0;
      req_d = bus.disp_req;
      if (bus.alarm === 1'b1) begin
        acnt++;
        if (ack_on && acnt == ack_lat) bus.ack = 1'b1;
      end else acnt = 0;
    end
  end

  typedef struct {
    logic [3:0]   en;
    logic [127:0] s;
    logic [15:0]  t;
    logic [3:0]   exp_p;
    int           exp_u;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n;
    vecs[0] = '{4'b0001, ent(0, 16'h0830), 16'h0830, 4'b0001, 0};
    vecs[1] = '{4'b0001, ent(0, 16'hFFFF), 16'hFFFF, 4'b0000, -1};
    vecs[2] = '{4'b0000, ent(0, 16'h0830), 16'h0830, 4'b0000, -1};
    vecs[3] = '{4'b0100, ent(5, 16'h1745), 16'h1745, 4'b0100, 2};
    vecs[4] = '{4'b1111, ent(0, 16'h0830) & ent(7, 16'h0830), 16'h0830, 4'b1001, 0};
    vecs[5] = '{4'b0001, ent(0, 16'h08A0), 16'h08A0, 4'b0000, -1};
    vecs[6] = '{4'b0001, ent(0, 16'h0830), 16'h0831, 4'b0000, -1};
    vecs[7] = '{4'b1000, ent(6, 16'h2359), 16'h2359, 4'b1000, 3};
    vecs[8] = '{4'b0010, ent(3, 16'h0000), 16'h0000, 4'b0010, 1};

    RST = 1'b0; tiempo = 16'h0000; sched = '1; user_en = '0;
    step(2);
    chk("rst_disp_req", 32'(bus.disp_req), 0);
    chk("rst_alarm", 32'(bus.alarm), 0);
    chk("rst_missed", 32'(bus.missed), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_disp_user", 32'(bus.disp_user), 0);

    // Scan table: servo never answers, so the first served user stays in DISPENSE.
    srv_lat = 100000; ack_on = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp_q.delete();
      if (vecs[i].exp_u >= 0) exp_q.push_back(vecs[i].exp_u);
      do_reset(vecs[i].en, vecs[i].s, vecs[i].t);
      step(16);
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].exp_p));
      chk($sformatf("vec%0d_served", i), 32'(exp_q.size()), 0);
    end

    // Single dose.
    exp_q.delete(); srv_lat = 3; ack_on = 1'b1; ack_lat = 5; miss_seen = 0;
    do_reset(4'b0001, ent(0, 16'h0830), 16'h0829);
    step(14);
    chk("sd_pre_pending", 32'(pending), 0);
    exp_q.push_back(0);
    tiempo = 16'h0830;
    n = 0; while (pending !== 4'b0001 && n < 20) begin step(1); n++; end
    chk("sd_pending", 32'(pending), 1);
    n = 0; while (bus.alarm !== 1'b1 && n < 30) begin step(1); n++; end
    chk("sd_alarm_on", 32'(bus.alarm), 1);
    chk("sd_alarm_user", 32'(bus.disp_user), 0);
    n = 0; while (bus.alarm === 1'b1 && n < 30) begin step(1); n++; end
    chk("sd_alarm_off", 32'(bus.alarm), 0);
    chk("sd_pending_clr", 32'(pending), 0);
    step(3);
    chk("sd_no_missed", 32'(miss_seen), 0);

    // Round robin, two minutes in a row.
    exp_q.delete(); srv_lat = 1; ack_lat = 1;
    do_reset(4'b1101, ent(0, 16'h1200) & ent(5, 16'h1200) & ent(6, 16'h1200) &
                      ent(1, 16'h1201) & ent(4, 16'h1201) & ent(7, 16'h1201), 16'h1159);
    step(14);
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(3);
    tiempo = 16'h1200;
    n = 0; while ((pending !== 0 || exp_q.size() != 0 || bus.alarm !== 1'b0) && n < 200) begin step(1); n++; end
    chk("rr1_done", 32'(n < 200), 1);
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(3);
    tiempo = 16'h1201;
    step(2);
    n = 0; while ((pending !== 0 || exp_q.size() != 0 || bus.alarm !== 1'b0) && n < 200) begin step(1); n++; end
    chk("rr2_done", 32'(n < 200), 1);

    // Alarm timeout.
    exp_q.delete(); ack_on = 1'b0; miss_seen = 0;
    do_reset(4'b0001, ent(0, 16'h1530), 16'h1529);
    step(14);
    exp_q.push_back(0);
    tiempo = 16'h1530;
    n = 0; while (bus.alarm !== 1'b1 && n < 40) begin step(1); n++; end
    chk("to_alarm_on", 32'(bus.alarm), 1);
    n = 0; while (bus.alarm === 1'b1 && n < 100) begin n++; step(1); end
    chk("to_alarm_len", 32'(n), ATO);
    step(3);
    chk("to_missed_once", 32'(miss_seen), 1);
    chk("to_pending_clr", 32'(pending), 0);
`ifdef DOSE_MISSED_CNT_EN
    chk("to_missed_cnt", 32'(missed_cnt[7:0]), 1);
`endif

    // Minute change during ALERT is deferred to the next IDLE.
    exp_q.delete(); ack_on = 1'b1; ack_lat = 15;
    do_reset(4'b0011, ent(0, 16'h0900) & ent(2, 16'h0901), 16'h0859);
    step(14);
    exp_q.push_back(0);
    tiempo = 16'h0900;
    n = 0; while (bus.alarm !== 1'b1 && n < 40) begin step(1); n++; end
    chk("df_alarm_on", 32'(bus.alarm), 1);
    tiempo = 16'h0901;
    step(3);
    chk("df_pending_hold", 32'(pending), 1);
    exp_q.push_back(1);
    n = 0; while (pending[1] !== 1'b1 && n < 40) begin step(1); n++; end
    chk("df_pending1", 32'(pending[1]), 1);
    n = 0; while ((pending !== 0 || exp_q.size() != 0 || bus.alarm !== 1'b0) && n < 200) begin step(1); n++; end
    chk("df_done", 32'(n < 200), 1);

    // Async reset in DISPENSE.
    exp_q.delete(); srv_lat = 100000;
    do_reset(4'b0001, ent(0, 16'h0830), 16'h0829);
    step(14);
    exp_q.push_back(0);
    tiempo = 16'h0830;
    n = 0; while (bus.disp_req !== 1'b1 && n < 30) begin step(1); n++; end
    chk("ar_disp_req_on", 32'(bus.disp_req), 1);
    #3 RST = 1'b0;
    #1;
    chk("ar_disp_req_off", 32'(bus.disp_req), 0);
    chk("ar_alarm_off", 32'(bus.alarm), 0);
    chk("ar_pending_off", 32'(pending), 0);
    exp_q.push_back(0);
    @(posedge clk); #1; RST = 1'b1;
    n = 0; while (bus.disp_req !== 1'b1 && n < 30) begin step(1); n++; end
    chk("ar_rescan_req", 32'(bus.disp_req), 1);
    chk("ar_rescan_pending", 32'(pending), 1);

    RST = 1'b0;
    step(2);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dose_scheduler.md
Name: dose_scheduler

Overview:
- Sequences the dispenser servos and the alarm speaker against the stored per-user dose times.
- Watches the running BCD clock and detects each new minute.
- Scans every user's dose slots and marks matching users pending, then serves them one at a time round-robin: a dispense handshake with the servo driver, then an alarm that the user acknowledges from the keypad.
- Sits between the user-record store, the chronometer, the PWM servo block and the speaker tone gate. Clocked from the 10 kHz system tick.

Parameters:
- NUSR, 4, number of user records.
- SLOTS, 2, dose times per user.
- ALARM_TO, 600000, alarm timeout in clk cycles (60 s at 10 kHz).

Ports:
- clk  in  1  10 kHz operating clock.
- RST  in  1  asynchronous active-low reset.
- tiempo  in  16  current time, BCD {H1,H0,M1,M0}.
- sched  in  NUSR*SLOTS*16  dose times, BCD {H1,H0,M1,M0}. Entry k = user k/SLOTS, slot k%SLOTS, at bits [16k+15:16k].
- user_en  in  NUSR  1 = user record valid.
- ack  in  1  one-cycle keypad confirm pulse.
- disp_req  out  1  request to servo driver to dispense.
- disp_user  out  2  user index being served; valid while disp_req or alarm is high.
- disp_ack  in  1  one-cycle pulse from servo driver: dispense complete.
- alarm  out  1  enables the speaker tone.
- pending  out  NUSR  users with an unserved dose.
- missed  out  1  one-cycle pulse on alarm timeout.

Behaviour:
- Reset (RST low, async):
  - States and signals: state = IDLE; disp_req, alarm, missed, pending and disp_user all 0.
  - Arbitration and timers: rr_ptr = NUSR-1, so user 0 is served first. Alarm counter = 0.
  - Minute tracking: last_min = 16'hFFFF, so the first valid tiempo counts as a change. min_flag = 0.
  - Reset mid-operation abandons any dispense or alarm immediately, with no missed pulse.
- Minute detect (every cycle, in any state): if tiempo != last_min, then last_min <= tiempo and min_flag <= 1.
- States:
  - IDLE: if min_flag, clear min_flag and go to SCAN with idx = 0. Otherwise, if pending != 0, go to GRANT. Otherwise stay.
  - SCAN: one entry per cycle, so the scan takes NUSR*SLOTS cycles.
    - A match sets pending[u] when user_en[u] = 1, every digit of the entry is <= 9, and the entry equals last_min.
    - Entries with a digit > 9 (e.g. 16'hFFFF) mean "slot unused" and never match.
    - A match on an already-set bit leaves it set (no double dose).
    - After the last entry, go to IDLE.
  - GRANT (1 cycle): pick the first set pending bit searching from rr_ptr+1, wrapping at NUSR. Load disp_user and rr_ptr with it. Go to DISPENSE. disp_req rises the next cycle.
  - DISPENSE: hold disp_req = 1 until disp_ack is sampled high. Then drop disp_req, go to ALERT, clear the alarm counter.
    - disp_ack sampled outside DISPENSE is ignored.
    - No timeout in this state; the servo driver must always answer.
  - ALERT: alarm = 1 while the counter increments each cycle.
    - ack high: clear pending[disp_user], alarm = 0, go to IDLE.
    - Counter reaches ALARM_TO-1 without ack: clear pending[disp_user], pulse missed for 1 cycle, alarm = 0, go to IDLE.
    - ack and timeout in the same cycle: ack wins, no missed pulse.
- A minute change during DISPENSE/ALERT only sets min_flag; the scan runs on the next IDLE. Two minute changes before that IDLE collapse into one scan of the latest minute.
- A user with user_en dropped while pending stays pending until served. The block does not consult user_en after the scan.
- ack outside ALERT is ignored.

Optional Feature:
- Macro: DOSE_MISSED_CNT_EN.
- Defined: adds output missed_cnt, 8*NUSR bits, one byte per user. The byte for disp_user increments on each timeout and saturates at 8'hFF. It resets to 0 only via RST.
- Undefined: the port and the counters do not exist; the missed pulse is unchanged.

Test Plan:
- Single dose. Setup: user_en = 4'b0001, sched entry0 = 16'h0830, tiempo changes 0829 -> 0830. Required: SCAN sets pending = 4'b0001; disp_req rises with disp_user = 0. Then drive disp_ack: alarm = 1. Then pulse ack: alarm = 0, pending = 0, no missed pulse.
- Round robin. Setup: users 0, 2, 3 all due at 1200, servo answers immediately. Required: served order 0, 2, 3. Then all due again at 1201: served order 0, 2, 3 again, because rr_ptr wrapped from 3.
- Timeout. Setup: ALARM_TO = 20, no ack. Required: alarm high exactly 20 cycles, missed pulses once, pending bit cleared. With DOSE_MISSED_CNT_EN defined: missed_cnt[7:0] = 1.
- Deferred scan. Setup: minute changes 0900 -> 0901 while in ALERT; user 1 due at 0901. Required: after ack, the next IDLE runs SCAN and sets pending[1].
- Invalid/disabled slots. Setup: entry = 16'hFFFF with tiempo = 16'hFFFF presented; also a matching entry whose user_en bit is 0. Required: pending stays 0 in both cases.
- Async reset. Setup: RST low during DISPENSE. Required: disp_req, alarm and pending drop to 0 immediately. After release, the first tiempo triggers a scan.
